// File: rtl/fifo_pkg.sv
// fifo_pkg: defaults, Gray-code helpers and parameter legality check for async_fifo_param.
package fifo_pkg;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_AEMPTY_TH   = 2;
    localparam int MAX_PTR_W       = 32;
    typedef logic [MAX_PTR_W-1:0] ptr_t;
    // Callers zero-extend narrower pointers; leading zeros leave both conversions exact.
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
    function automatic bit params_ok(input int addr_w, input int sync_stages, input int aempty_th, input int afull_th);
        return addr_w >= 2 && addr_w < MAX_PTR_W && sync_stages >= 2 && sync_stages <= 4
            && aempty_th < afull_th && afull_th <= (1 << addr_w);
    endfunction
endpackage

// File: rtl/cdc_sync_bus.sv
// cdc_sync_bus: multi-flop synchroniser for a Gray-coded bus (one bit changes per update).
module cdc_sync_bus #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] sr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else sr <= {sr[STAGES-2:0], d};
    assign q = sr[STAGES-1];
endmodule

// File: rtl/async_fifo_param.sv
// async_fifo_param: dual-clock FIFO with Gray pointer crossing, level/threshold flags
// and sticky overflow/underflow indicators.
module async_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int AFULL_TH    = 2**ADDR_W - 2,
    parameter int AEMPTY_TH   = DEF_AEMPTY_TH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              w_clk,
    input  logic              rst_n,
    input  logic              r_clk,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    output logic              w_afull,
    output logic [ADDR_W:0]   w_level,
    output logic              w_ovf,
    input  logic              w_ovf_clr,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_empty,
    output logic              r_aempty,
    output logic [ADDR_W:0]   r_level,
    output logic              r_udf,
    input  logic              r_udf_clr
);
    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PW-1:0] TOP2 = {2'b11, {(PW-2){1'b0}}};

    if (!params_ok(ADDR_W, SYNC_STAGES, AEMPTY_TH, AFULL_TH)) begin : g_bad_params
        $error("async_fifo_param: illegal parameter combination");
    end

    // Reset asserts asynchronously, releases synchronously in each domain.
    logic [1:0] w_rs, r_rs;
    logic       w_rst_n, r_rst_n;
    always_ff @(posedge w_clk or negedge rst_n)
        if (!rst_n) w_rs <= '0;
        else w_rs <= {w_rs[0], 1'b1};
    always_ff @(posedge r_clk or negedge rst_n)
        if (!rst_n) r_rs <= '0;
        else r_rs <= {r_rs[0], 1'b1};
    assign w_rst_n = w_rs[1];
    assign r_rst_n = r_rs[1];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] wbin, wgray, wbin_nx, wgray_nx, rgray_s, w_level_nx;
    logic [PW-1:0] rbin, rgray, rbin_nx, rgray_nx, wgray_s, r_level_nx;
    logic          w_push, r_pop;

    cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_w2r (
        .clk(r_clk), .rst_n(r_rst_n), .d(wgray), .q(wgray_s)
    );
    cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_r2w (
        .clk(w_clk), .rst_n(w_rst_n), .d(rgray), .q(rgray_s)
    );

    always_comb begin
        w_push     = w_en && !w_full;
        wbin_nx    = wbin + PW'(w_push);
        wgray_nx   = PW'(bin2gray(ptr_t'(wbin_nx)));
        w_level_nx = wbin_nx - PW'(gray2bin(ptr_t'(rgray_s)));
        r_pop      = r_en && !r_empty;
        rbin_nx    = rbin + PW'(r_pop);
        rgray_nx   = PW'(bin2gray(ptr_t'(rbin_nx)));
        r_level_nx = PW'(gray2bin(ptr_t'(wgray_s))) - rbin_nx;
    end

    always_ff @(posedge w_clk)
        if (w_push) mem[wbin[ADDR_W-1:0]] <= w_data;

    always_ff @(posedge w_clk or negedge w_rst_n)
        if (!w_rst_n) begin
            wbin    <= '0;
            wgray   <= '0;
            w_full  <= 1'b0;
            w_afull <= 1'b0;
            w_level <= '0;
            w_ovf   <= 1'b0;
        end else begin
            wbin    <= wbin_nx;
            wgray   <= wgray_nx;
            w_full  <= wgray_nx == (rgray_s ^ TOP2);
            w_afull <= w_level_nx >= PW'(AFULL_TH);
            w_level <= w_level_nx;
            w_ovf   <= (w_en && w_full) || (w_ovf && !w_ovf_clr);
        end

    always_ff @(posedge r_clk or negedge r_rst_n)
        if (!r_rst_n) begin
            rbin     <= '0;
            rgray    <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_level  <= '0;
            r_udf    <= 1'b0;
            r_data   <= '0;
        end else begin
            rbin     <= rbin_nx;
            rgray    <= rgray_nx;
            r_empty  <= rgray_nx == wgray_s;
            r_aempty <= r_level_nx <= PW'(AEMPTY_TH);
            r_level  <= r_level_nx;
            r_udf    <= (r_en && r_empty) || (r_udf && !r_udf_clr);
            if (r_pop) r_data <= mem[rbin[ADDR_W-1:0]];
        end
endmodule

// File: tb/tb_async_fifo_param.sv
// tb_async_fifo_param: directed checks of async_fifo_param at default and wide/deep parameters.
module tb_async_fifo_param;
    localparam int SMP = 100;
    logic w_clk = 0, r_clk = 0, rst_n = 1;
    logic w_en = 0, w_ovf_clr = 0, r_en = 0, r_udf_clr = 0;
    logic [7:0] w_data = 0, r_data;
    logic w_full, w_afull, w_ovf, r_empty, r_aempty, r_udf;
    logic [4:0] w_level, r_level;
    logic b_w_en = 0, b_r_en = 0;
    logic [31:0] b_w_data = 0, b_r_data;
    logic b_w_full, b_w_afull, b_w_ovf, b_r_empty, b_r_aempty, b_r_udf;
    logic [6:0] b_w_level, b_r_level;
    int total = 0, bad = 0;
    int wn, rn, wcyc, rcyc, errs, n;

    // 12 ns / 11 ns clocks in ps, offset so edges never coincide.
    always #6000 w_clk = ~w_clk;
    initial begin
        #250;
        forever #5500 r_clk = ~r_clk;
    end

    async_fifo_param dut (
        .w_clk(w_clk), .rst_n(rst_n), .r_clk(r_clk),
        .w_en(w_en), .w_data(w_data), .w_full(w_full), .w_afull(w_afull),
        .w_level(w_level), .w_ovf(w_ovf), .w_ovf_clr(w_ovf_clr),
        .r_en(r_en), .r_data(r_data), .r_empty(r_empty), .r_aempty(r_aempty),
        .r_level(r_level), .r_udf(r_udf), .r_udf_clr(r_udf_clr)
    );

    async_fifo_param #(.DATA_W(32), .ADDR_W(6), .SYNC_STAGES(3)) dut_b (
        .w_clk(w_clk), .rst_n(rst_n), .r_clk(r_clk),
        .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full), .w_afull(b_w_afull),
        .w_level(b_w_level), .w_ovf(b_w_ovf), .w_ovf_clr(1'b0),
        .r_en(b_r_en), .r_data(b_r_data), .r_empty(b_r_empty), .r_aempty(b_r_aempty),
        .r_level(b_r_level), .r_udf(b_r_udf), .r_udf_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wtick();
        @(posedge w_clk);
        #SMP;
    endtask

    task automatic rtick();
        @(posedge r_clk);
        #SMP;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_w_full"}, w_full, 0);
        chk({tag, "_w_afull"}, w_afull, 0);
        chk({tag, "_w_level"}, w_level, 0);
        chk({tag, "_w_ovf"}, w_ovf, 0);
        chk({tag, "_r_empty"}, r_empty, 1);
        chk({tag, "_r_aempty"}, r_aempty, 1);
        chk({tag, "_r_level"}, r_level, 0);
        chk({tag, "_r_udf"}, r_udf, 0);
        chk({tag, "_r_data"}, r_data, 0);
    endtask

    initial begin
        #1000 rst_n = 0;
        repeat (4) wtick();
        repeat (4) rtick();
        check_reset("rst");
        rst_n = 1;
        repeat (4) wtick();
        repeat (4) rtick();

        // Fill and drain
        for (int i = 0; i < 16; i++) begin
            w_en = 1;
            w_data = 8'(i);
            wtick();
            chk("fill_level", w_level, i + 1);
            chk("fill_afull", w_afull, i + 1 >= 14);
            chk("fill_full", w_full, i == 15);
        end
        w_data = 8'hAA;
        wtick();
        w_en = 0;
        chk("ovf_set", w_ovf, 1);
        chk("ovf_level", w_level, 16);
        w_ovf_clr = 1;
        wtick();
        w_ovf_clr = 0;
        chk("ovf_clr", w_ovf, 0);
        n = 0;
        while (r_level != 16 && n < 20) begin rtick(); n++; end
        chk("drain_level", r_level, 16);
        for (int i = 0; i < 16; i++) begin
            r_en = 1;
            rtick();
            chk("drain_data", r_data, i);
        end
        r_en = 0;
        chk("drain_empty", r_empty, 1);
        chk("drain_aempty", r_aempty, 1);
        chk("drain_udf", r_udf, 0);
        repeat (5) wtick();
        chk("drain_w_level", w_level, 0);
        chk("drain_w_full", w_full, 0);

        // Streaming 1000 words
        wn = 0; rn = 0; wcyc = 0; rcyc = 0; errs = 0;
        fork
            begin
                while (wn < 1000 && wcyc < 20000) begin
                    wtick();
                    wcyc++;
                    if (w_en) wn++;
                    if (wn < 1000 && !w_full) begin
                        w_en = 1;
                        w_data = 8'(wn);
                    end else w_en = 0;
                end
                w_en = 0;
            end
            begin
                while (rn < 1000 && rcyc < 20000) begin
                    rtick();
                    rcyc++;
                    if (r_en) begin
                        if (r_data !== 8'(rn)) errs++;
                        rn++;
                    end
                    r_en = rn < 1000 && !r_empty;
                end
                r_en = 0;
            end
        join
        chk("stream_written", wn, 1000);
        chk("stream_read", rn, 1000);
        chk("stream_errs", errs, 0);
        chk("stream_ovf", w_ovf, 0);
        chk("stream_udf", r_udf, 0);
        chk("stream_empty", r_empty, 1);

        // Underflow
        r_en = 1;
        rtick();
        r_en = 0;
        chk("udf_set", r_udf, 1);
        chk("udf_data_hold", r_data, 8'hE7);
        chk("udf_empty", r_empty, 1);
        r_udf_clr = 1;
        rtick();
        r_udf_clr = 0;
        chk("udf_clr", r_udf, 0);
        r_en = 1;
        r_udf_clr = 1;
        rtick();
        r_en = 0;
        r_udf_clr = 0;
        chk("udf_set_wins", r_udf, 1);
        r_udf_clr = 1;
        rtick();
        r_udf_clr = 0;
        chk("udf_clr2", r_udf, 0);

        // Latency of a single write
        w_en = 1;
        w_data = 8'h3C;
        wtick();
        w_en = 0;
        n = 0;
        while (r_empty && n < 10) begin rtick(); n++; end
        chk("lat_le3", n <= 3, 1);
        chk("lat_level", r_level, 1);
        chk("lat_aempty", r_aempty, 1);
        r_en = 1;
        rtick();
        r_en = 0;
        chk("lat_data", r_data, 8'h3C);
        chk("lat_empty", r_empty, 1);

        // Reset mid-stream with 9 words stored
        for (int i = 0; i < 9; i++) begin
            w_en = 1;
            w_data = 8'(8'h10 + i);
            wtick();
        end
        w_en = 0;
        repeat (4) rtick();
        chk("mid_r_level", r_level, 9);
        #1000 rst_n = 0;
        #SMP;
        check_reset("mid");
        repeat (2) wtick();
        rst_n = 1;
        repeat (4) wtick();
        repeat (4) rtick();
        w_en = 1;
        w_data = 8'h55;
        wtick();
        w_en = 0;
        n = 0;
        while (r_empty && n < 10) begin rtick(); n++; end
        r_en = 1;
        rtick();
        r_en = 0;
        chk("post_rst_data", r_data, 8'h55);
        chk("post_rst_empty", r_empty, 1);
        chk("post_rst_level", r_level, 0);

        // Wide/deep instance
        b_w_en = 1;
        b_w_data = 32'hDEADBEEF;
        wtick();
        b_w_en = 0;
        n = 0;
        while (b_r_empty && n < 10) begin rtick(); n++; end
        chk("b_lat_le4", n <= 4, 1);
        b_r_en = 1;
        rtick();
        b_r_en = 0;
        chk("b_lat_data", b_r_data, 32'hDEADBEEF);
        repeat (6) wtick();
        chk("b_w_level0", b_w_level, 0);
        for (int i = 0; i < 64; i++) begin
            b_w_en = 1;
            b_w_data = 32'(32'hA5000000 + i);
            wtick();
            if (i == 62) chk("b_not_full_63", b_w_full, 0);
        end
        b_w_en = 0;
        chk("b_full_64", b_w_full, 1);
        chk("b_level_64", b_w_level, 64);
        chk("b_afull", b_w_afull, 1);
        n = 0;
        while (b_r_level != 64 && n < 20) begin rtick(); n++; end
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            b_r_en = 1;
            rtick();
            if (b_r_data !== 32'(32'hA5000000 + i)) errs++;
        end
        b_r_en = 0;
        chk("b_data_errs", errs, 0);
        chk("b_empty", b_r_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/async_fifo_param.md
# async_fifo_param

Parametrised dual-clock FIFO: the next generation of the team's 8-bit async FIFO, generalised in data width, depth and synchroniser depth. It adds almost-full/almost-empty flags, per-domain fill levels and sticky overflow/underflow flags. It sits between a producer in the w_clk domain and a consumer in the r_clk domain, and is the standard CDC buffer for streaming data paths.

## Interface
- DATA_W, 8, data word width
- ADDR_W, 4, address width; depth = 2^ADDR_W (16)
- AFULL_TH, 2^ADDR_W-2, w_afull asserts when w_level >= AFULL_TH
- AEMPTY_TH, 2, r_aempty asserts when r_level <= AEMPTY_TH
- SYNC_STAGES, 2, flops per pointer synchroniser (legal range 2..4)

Ports:
- w_clk  in  1  write clock
- rst_n  in  1  reset, asynchronous, active-low; clock w_clk
- r_clk  in  1  read clock
- w_en  in  1  write request
- w_data  in  DATA_W  write data
- w_full  out  1  FIFO full (w_clk)
- w_afull  out  1  almost full (w_clk)
- w_level  out  ADDR_W+1  words stored, as seen from w_clk
- w_ovf  out  1  sticky: write attempted while full
- w_ovf_clr  in  1  clears w_ovf (w_clk)
- r_en  in  1  read request
- r_data  out  DATA_W  read data, registered
- r_empty  out  1  FIFO empty (r_clk)
- r_aempty  out  1  almost empty (r_clk)
- r_level  out  ADDR_W+1  words stored, as seen from r_clk
- r_udf  out  1  sticky: read attempted while empty
- r_udf_clr  in  1  clears r_udf (r_clk)

## Operation
- Memory: 2^ADDR_W x DATA_W dual-port array. Written on w_clk and read on r_clk.
- Pointers: binary plus Gray, ADDR_W+1 bits each. The extra MSB distinguishes full from empty.
- Write: on a w_clk edge with w_en && !w_full, store w_data at wptr[ADDR_W-1:0] and increment wptr.
- w_en while full: the word is dropped, pointers hold, and w_ovf sets.
- Read: on an r_clk edge with r_en && !r_empty, load r_data from mem[rptr] and increment rptr.
- r_data holds its value when no read is accepted.
- r_en while empty: pointers hold, r_data holds, and r_udf sets.
- Gray pointers cross domains through SYNC_STAGES-flop synchronisers: wgray into r_clk, rgray into w_clk.
- w_full is registered. It is computed from the next wgray versus the synchronised rgray, with the two MSBs inverted.
- r_empty is registered. It is computed from the next rgray == the synchronised wgray.
- w_level = wbin − gray2bin(synchronised rgray). r_level = gray2bin(synchronised wgray) − rbin. Both use modulo 2^(ADDR_W+1) arithmetic and are registered.
- Levels are conservative: w_level never under-reports and r_level never over-reports.
- w_afull and r_aempty are registered threshold compares on the next level.
- Sticky flags clear on reset or on their _clr input. If set and clear occur in the same cycle, set wins.
- Pointer wrap: pointers roll over naturally at 2^(ADDR_W+1). No special case is needed.

## Timing
- Reset values: w_full=0, w_afull=0, w_level=0, w_ovf=0, r_empty=1, r_aempty=1, r_level=0, r_udf=0, r_data=0. All pointers and synchroniser flops reset to 0.
- Reset synchronisation: rst_n asserts asynchronously in both domains. Deassertion passes through an internal 2-flop synchroniser per domain.
- Reset mid-operation: contents are discarded and all outputs return to their reset values within the assertion.
- Write-domain flags: w_full and w_afull update on the same edge that accepts the write that causes them.
- Read-domain flags: r_empty and r_aempty update on the same edge that accepts the read that causes them.
- Write to read visibility: r_empty deasserts SYNC_STAGES+1 r_clk edges after the accepting w_clk edge, worst case.
- Read to write visibility: w_full deasserts SYNC_STAGES+1 w_clk edges after the accepting r_clk edge, worst case.
- Read latency: r_data is valid immediately after the r_clk edge that accepted r_en.
- Simultaneous read and write while neither full nor empty: both are accepted. Each local level updates with the local operation only.
- Back-to-back throughput: one word per clock per side, sustained.

## Structure
- Package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width;
  - default-parameter localparams;
  - the elaboration check: ADDR_W >= 2, SYNC_STAGES in 2..4, AEMPTY_TH < AFULL_TH <= 2^ADDR_W.
- Sub-module cdc_sync_bus (WIDTH, STAGES): a multi-flop synchroniser for a Gray bus. It is instantiated twice.
- Remaining logic lives in async_fifo_param: memory, write control and read control.

## Test plan
Default parameters, w_clk period 12 ns, r_clk period 11 ns.

1. Fill and drain:
   - Write 0x00–0x0F with r_en=0 -> w_full=1 after the 16th write, w_level=16, w_afull=1 from level 14.
   - 17th write (0xAA) -> dropped and w_ovf=1.
   - Then read 16 -> r_data sequence 0x00..0x0F, r_empty=1, no 0xAA.
2. Streaming: a free-running counter writes whenever !w_full and the checker reads whenever !r_empty, for 1000 words -> every word matches its counter, pointers wrap more than 30 times, and no ovf or udf flag sets.
3. Underflow:
   - r_en=1 while empty -> r_udf=1 and r_data holds.
   - Pulse r_udf_clr -> r_udf=0.
   - Set and clear in the same cycle -> r_udf stays 1.
4. Latency: a single write into an empty FIFO -> r_empty falls no later than the 3rd r_clk edge, r_level=1, r_aempty stays 1.
5. Reset mid-stream: assert rst_n low with 9 words stored -> all outputs return to reset values. After release, writing 0x55 reads back exactly 0x55.
6. Parameter sweep: DATA_W=32, ADDR_W=6, SYNC_STAGES=3 -> w_full at 64 words, data intact, r_empty latency at most 4 r_clk edges.
